// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared states, defaults and strobe indices for the division sequencer
package div_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam int C_LOAD_M  = 0;
  localparam int C_LOAD_Q  = 1;
  localparam int C_SETQ    = 2;
  localparam int C_SUB     = 3;
  localparam int C_SHIFT   = 4;
  localparam int C_RESTORE = 5;
  localparam int C_OUT_Q   = 6;
  localparam int C_OUT_A   = 7;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_Q  = 4'd1,
    S_LOAD_M  = 4'd2,
    S_CHECK   = 4'd3,
    S_SHIFT   = 4'd4,
    S_SUB     = 4'd5,
    S_SETQ    = 4'd6,
    S_RESTORE = 4'd7,
    S_OUT_Q   = 4'd8,
    S_OUT_A   = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  // One-hot strobe vector (bit n drives cn) for the cycle spent in state s
  function automatic logic [7:0] strobe_of(input state_t s);
    logic [7:0] v;
    v = '0;
    case (s)
      S_LOAD_Q:  v[C_LOAD_Q]  = 1'b1;
      S_LOAD_M:  v[C_LOAD_M]  = 1'b1;
      S_SHIFT:   v[C_SHIFT]   = 1'b1;
      S_SUB:     v[C_SUB]     = 1'b1;
      S_SETQ:    v[C_SETQ]    = 1'b1;
      S_RESTORE: v[C_RESTORE] = 1'b1;
      S_OUT_Q:   v[C_OUT_Q]   = 1'b1;
      S_OUT_A:   v[C_OUT_A]   = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// div_iter_cnt: saturating iteration counter with a flag on the final iteration
module div_iter_cnt
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  assign last = cnt == CNT_W'(WIDTH - 1);

  // Clear wins over increment; stepping stops at the last iteration so cnt never wraps
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !last) ? cnt + 1'b1 : cnt;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: Moore sequencer emitting one-hot c0..c7 strobes for restoring division
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic sign,
  input  logic m_zero,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state, nxt;
  logic err_f, err_nxt;
  logic cnt_clr, cnt_inc, last;
  logic [7:0] strobe;

  div_iter_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (last)
  );

  assign {c7, c6, c5, c4, c3, c2, c1, c0} = strobe;

  // Next-state, counter control and error-flag update
  always_comb begin
    nxt     = state;
    err_nxt = err_f;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_IDLE:    nxt = start ? S_LOAD_Q : S_IDLE;
      S_LOAD_Q:  nxt = S_LOAD_M;
      S_LOAD_M:  nxt = S_CHECK;
      S_CHECK: begin
        nxt     = m_zero ? S_DONE : S_SHIFT;
        err_nxt = m_zero;
        cnt_clr = !m_zero;
      end
      S_SHIFT:   nxt = S_SUB;
      S_SUB:     nxt = S_SETQ;
      S_SETQ: begin
        nxt     = sign ? S_RESTORE : last ? S_OUT_Q : S_SHIFT;
        cnt_inc = !sign && !last;
      end
      S_RESTORE: begin
        nxt     = last ? S_OUT_Q : S_SHIFT;
        cnt_inc = !last;
      end
      S_OUT_Q:   nxt = S_OUT_A;
      S_OUT_A:   nxt = S_DONE;
      S_DONE: begin
        nxt     = S_IDLE;
        err_nxt = 1'b0;
      end
      default:   nxt = S_IDLE;
    endcase
  end

  // State register with outputs registered from the state being entered
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      err_f  <= 1'b0;
      strobe <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= nxt;
      err_f  <= err_nxt;
      strobe <= strobe_of(nxt);
      busy   <= nxt != S_IDLE;
      done   <= nxt == S_DONE;
      err    <= (nxt == S_DONE) && err_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed checks of the division sequencer against a restoring-division datapath model
module tb_div_seq_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic start = 1'b0;
  logic sign, m_zero;
  logic c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err;

  logic [32:0] a_reg = '0;
  logic [31:0] q_reg = '0;
  logic [31:0] m_reg = '0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;

  int errors = 0;
  int checks = 0;

  int cyc, dcyc, n3, n4, n5, nhi, ndone, nerr, nlow, nmulti;
  logic [31:0] q_out, a_out;
  logic busy_after;

  div_seq_ctrl dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .start  (start),
    .sign   (sign),
    .m_zero (m_zero),
    .c0     (c0),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .c5     (c5),
    .c6     (c6),
    .c7     (c7),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 CLK = ~CLK;

  assign sign   = a_reg[32];
  assign m_zero = m_reg == 32'd0;

  // Reference A/Q/M datapath obeying the strobes
  always @(posedge CLK) begin
    if (c1) q_reg <= dividend;
    if (c0) begin
      m_reg <= divisor;
      a_reg <= '0;
    end
    if (c4) {a_reg, q_reg} <= {a_reg[31:0], q_reg, 1'b0};
    if (c3) a_reg <= a_reg - {1'b0, m_reg};
    if (c2) q_reg[0] <= ~a_reg[32];
    if (c5) a_reg <= a_reg + {1'b0, m_reg};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int mid);
    if (!busy) nlow++;
    if ($countones({c7, c6, c5, c4, c3, c2, c1, c0}) > 1) nmulti++;
    n3 += int'(c3);
    n4 += int'(c4);
    n5 += int'(c5);
    nhi += int'(c2 | c3 | c4 | c5 | c6 | c7);
    if (c6) q_out = q_reg;
    if (c7) a_out = a_reg[31:0];
    start = (mid != 0) && c3 && (n3 == mid);
    if (done) begin
      ndone++;
      nerr += int'(err);
      if (dcyc == 0) dcyc = cyc;
    end
  endtask

  task automatic run(input logic [31:0] dd, input logic [31:0] dv, input int mid);
    dividend = dd;
    divisor = dv;
    {dcyc, n3, n4, n5, nhi, ndone, nerr, nlow, nmulti} = '0;
    q_out = 'x;
    a_out = 'x;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 200 && dcyc == 0; i++) begin
      sample(mid);
      if (dcyc == 0) begin
        @(negedge CLK);
        cyc++;
      end
    end
    start = 1'b0;
    @(negedge CLK);
    busy_after = busy;
    if (done) ndone++;
  endtask

  task automatic expect_ok(input string tag, input logic [31:0] q, input logic [31:0] a,
                           input int restores, input int cycles);
    check({tag, ".q"}, 64'(q_out), 64'(q));
    check({tag, ".a"}, 64'(a_out), 64'(a));
    check({tag, ".cycles"}, 64'(dcyc), 64'(cycles));
    check({tag, ".c4"}, 64'(n4), 64'd32);
    check({tag, ".c5"}, 64'(n5), 64'(restores));
    check({tag, ".done"}, 64'(ndone), 64'd1);
    check({tag, ".err"}, 64'(nerr), 64'd0);
    check({tag, ".onehot"}, 64'(nmulti), 64'd0);
    check({tag, ".busy"}, 64'(nlow), 64'd0);
    check({tag, ".idle"}, 64'(busy_after), 64'd0);
  endtask

  initial begin
    #1;
    check("reset_outs", 64'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err}), 64'd0);
    #20;
    RESET = 1'b1;

    run(32'd100, 32'd7, 0);
    expect_ok("d100_7", 32'd14, 32'd2, 29, 131);

    run(32'd0, 32'd5, 0);
    expect_ok("d0_5", 32'd0, 32'd0, 32, 134);

    run(32'hFFFF_FFFF, 32'd1, 0);
    expect_ok("dff_1", 32'hFFFF_FFFF, 32'd0, 0, 102);

    run(32'd9, 32'd0, 0);
    check("dz.cycles", 64'(dcyc), 64'd4);
    check("dz.err", 64'(nerr), 64'd1);
    check("dz.done", 64'(ndone), 64'd1);
    check("dz.strobes", 64'(nhi), 64'd0);
    check("dz.idle", 64'(busy_after), 64'd0);

    run(32'd100, 32'd7, 10);
    expect_ok("mid_start", 32'd14, 32'd2, 29, 131);

    dividend = 32'd100;
    divisor = 32'd7;
    n4 = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 200 && n4 < 20; i++) begin
      @(negedge CLK);
      n4 += int'(c4);
    end
    check("rst.reached", 64'(n4), 64'd20);
    check("rst.busy_before", 64'(busy), 64'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("rst.outs", 64'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err}), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst.stay_idle", 64'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, err}), 64'd0);

    run(32'd100, 32'd7, 0);
    expect_ok("after_rst", 32'd14, 32'd2, 29, 131);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencing controller for the 32-bit restoring-division datapath (A, Q and M registers plus adder/subtractor on the shared ibus/obus). On `start`, it emits a one-hot stream of control strobes `c0`..`c7`. The strobes load operands, run WIDTH shift/subtract/set-bit/restore iterations, detect divide-by-zero, and drive quotient then remainder onto obus. It is the only master of the `c*` lines in the division path.

## Interface
- `WIDTH`, default 32: operand width and iteration count.
- `CNT_W`, default 6: iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports (clock and reset first):
- `CLK`  in  1  clock, all state changes on the rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a division; sampled only in IDLE.
- `sign`  in  1  MSB of A after the subtract; valid in the SETQ cycle.
- `m_zero`  in  1  M register equals 0; valid in the CHECK cycle.
- `c0`  out  1  load M from ibus and clear A.
- `c1`  out  1  load Q from ibus (dividend).
- `c2`  out  1  write quotient bit: q[0] <= ~sign.
- `c3`  out  1  A <= A - M.
- `c4`  out  1  shift A:Q one step.
- `c5`  out  1  restore: A <= A + M.
- `c6`  out  1  Q drives obus.
- `c7`  out  1  A drives obus.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of operation.
- `err`  out  1  one-cycle pulse with `done` on divide-by-zero.

## Operation
- Moore FSM. Outputs decode from the state register only. At most one of `c0`..`c7` is high in any cycle.
- States and strobes:
  - IDLE: no strobe.
  - LOAD_Q: `c1`.
  - LOAD_M: `c0`.
  - CHECK: no strobe.
  - SHIFT: `c4`.
  - SUB: `c3`.
  - SETQ: `c2`.
  - RESTORE: `c5`.
  - OUT_Q: `c6`.
  - OUT_A: `c7`.
  - DONE: `done`; also `err` when entered via the divide-by-zero path.
- Transitions:
  - IDLE → LOAD_Q when `start` = 1.
  - LOAD_Q → LOAD_M.
  - LOAD_M → CHECK.
  - CHECK → DONE with the error flag set if `m_zero` = 1; otherwise → SHIFT with cnt cleared.
  - SHIFT → SUB → SETQ.
  - SETQ → RESTORE if `sign` = 1. Otherwise, if cnt = WIDTH-1 → OUT_Q; else cnt++ and → SHIFT.
  - RESTORE: same cnt test and increment as the SETQ non-restore exit.
  - OUT_Q → OUT_A → DONE → IDLE.
- Counter rules: cnt is CNT_W bits and never wraps. Exactly WIDTH SHIFT visits occur per non-error operation.
- Error flag: set on the CHECK → DONE error exit, cleared on leaving DONE. On the error path, `c2`..`c7` never assert.
- `start` outside IDLE is ignored; there is no queueing.
- The operand source on ibus for LOAD_Q/LOAD_M is the requester's responsibility: dividend in the LOAD_Q cycle, divisor in the LOAD_M cycle.

## Timing
- Reset (RESET = 0, asynchronous): state = IDLE, cnt = 0, error flag = 0. All outputs (`c0`..`c7`, `busy`, `done`, `err`) are 0 immediately, without waiting for a clock edge.
- Reset mid-operation aborts immediately; the datapath contents are undefined. After release, a new `start` is needed.
- `start` high at edge k puts `c1` high during cycle k+1.
- Latency from the `start` edge to the `done` cycle:
  - 3 cycles of load/check.
  - 3 cycles per iteration, plus 1 per restore.
  - 3 cycles of output.
  - Minimum 102 cycles (no restores), maximum 134 cycles (all restores), at WIDTH = 32.
  - Divide-by-zero: `done`/`err` in cycle 4.
- `sign` is sampled at the SETQ → next edge. `m_zero` is sampled at the CHECK → next edge.
- `busy` falls in the cycle after DONE. `start` may be asserted in that cycle and is accepted.

## Structure
- Package `div_seq_pkg`:
  - State enumeration with localparam encoding (4 bits).
  - Default WIDTH and CNT_W.
  - Strobe index constants C_LOAD_M = 0 … C_OUT_A = 7.
- Sub-module `div_iter_cnt`: clear/increment counter with a `last` flag (cnt == WIDTH-1) and asynchronous active-low reset.
- The FSM and one-hot output decode live in `div_seq_ctrl`.

## Test plan
- 100 / 7 with the reference datapath model → `c6` cycle obus = 14, `c7` cycle obus = 2. `done` once, `err` = 0, exactly 32 `c4` pulses.
- 0 / 5 → Q = 0, A = 0. 32 `c5` pulses (every SUB negative), `done` at cycle 134.
- 0xFFFFFFFF / 1 → Q = 0xFFFFFFFF, A = 0. No `c5` pulses, `done` at cycle 102.
- Divisor 0 → `done` and `err` high together in cycle 4. No `c2`..`c7` ever high, back to IDLE next cycle.
- `start` pulsed during SUB of iteration 10 → ignored. Result and cycle count identical to a clean run.
- RESET low during iteration 20 → all outputs 0 in the same cycle. After release, a fresh 100 / 7 run gives 14 r 2.
